// File: rtl/async_d_ff_pkg.sv
// Shared constants and helpers for the async_d_ff register primitive.
package async_d_ff_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 1024;

  // Default reset vector: all zeros. The caller casts it down to its own width.
  function automatic logic [MAX_WIDTH-1:0] default_reset(input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = '1;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < int'(width)) v[i] = 1'b0;
    end
    return v & ~v;
  endfunction

endpackage

// File: rtl/async_d_ff.sv
// Parameterizable D register with asynchronous active-high reset.
// Optional clock enable port `ce` when ASYNC_D_FF_CE_EN is defined.
module async_d_ff
  import async_d_ff_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(default_reset(WIDTH))
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ASYNC_D_FF_CE_EN
  input  logic             ce,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("async_d_ff: WIDTH must be in 1..1024");
  end

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
`ifdef ASYNC_D_FF_CE_EN
    if (ce) q_d = d;
`else
    q_d = d;
`endif
  end

  // Reset has priority; a clock edge coincident with rst high keeps RESET_VALUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RESET_VALUE;
    else     q_q <= q_d;
  end

  assign q = q_q;

`ifndef SYNTHESIS
  a_rst_known: assert property (@(posedge clk) !$isunknown(rst))
    else $error("async_d_ff: rst is X/Z at clock edge");
`endif

endmodule

// File: tb/tb_async_d_ff.sv
// Self-checking bench for async_d_ff: a 1-bit default instance driven on an
// absolute timeline, and an 8-bit instance with RESET_VALUE 8'hA5 driven from a vector table.
module tb_async_d_ff;

  logic       clk = 1'b0;
  logic       rst1, rst8;
  logic       ce1, ce8;
  logic [0:0] d1, q1;
  logic [7:0] d8, q8;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  async_d_ff u_dut1 (
    .clk(clk),
    .rst(rst1),
`ifdef ASYNC_D_FF_CE_EN
    .ce (ce1),
`endif
    .d  (d1),
    .q  (q1)
  );

  async_d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk(clk),
    .rst(rst8),
`ifdef ASYNC_D_FF_CE_EN
    .ce (ce8),
`endif
    .d  (d8),
    .q  (q8)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic push(input logic [7:0] e);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act);
    logic [7:0] e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: q=%h but scoreboard empty", name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: q=%h expected %h", name, act, e);
      end
    end
  endtask

  task automatic at(input time t);
    #(t - $time);
  endtask

  initial begin
    vecs[0] = '{"w8_reset",        1'b1, 8'h00, 8'hA5};
    vecs[1] = '{"w8_reset_hold",   1'b1, 8'h3C, 8'hA5};
    vecs[2] = '{"w8_capture_3c",   1'b0, 8'h3C, 8'h3C};
    vecs[3] = '{"w8_capture_ff",   1'b0, 8'hFF, 8'hFF};
    vecs[4] = '{"w8_capture_00",   1'b0, 8'h00, 8'h00};
    vecs[5] = '{"w8_capture_5a",   1'b0, 8'h5A, 8'h5A};
    vecs[6] = '{"w8_reset_mid",    1'b1, 8'h77, 8'hA5};
    vecs[7] = '{"w8_after_reset",  1'b0, 8'hC3, 8'hC3};

    ce1 = 1'b1; ce8 = 1'b1;
    rst1 = 1'b1; d1 = 1'b1;
    rst8 = 1'b1; d8 = 8'h00;

    // 1-bit instance on the absolute timeline (edges at 5, 15, 25, ...)
    push(8'h00);
    at(1);  chk("por_async", {7'b0, q1});
    at(3);  rst1 = 1'b0; push(8'h00);
    at(4);  chk("rst_fall_no_change", {7'b0, q1});
    push(8'h01);
    at(6);  chk("capture_t5", {7'b0, q1});
    d1 = 1'b0;
    at(9);  d1 = 1'b1; push(8'h01); chk("d_toggle_9", {7'b0, q1});
    at(12); d1 = 1'b0; push(8'h01);
    at(14); chk("d_toggle_12", {7'b0, q1});
    push(8'h00);
    at(16); chk("capture_t15", {7'b0, q1});
    push(8'h00);
    at(26); chk("hold_t25", {7'b0, q1});
    d1 = 1'b1; push(8'h01);
    at(36); chk("capture_t35", {7'b0, q1});
    at(37); rst1 = 1'b1; push(8'h00);
    at(38); chk("async_mid_cycle", {7'b0, q1});
    push(8'h00);
    at(46); chk("rst_hold_t45", {7'b0, q1});
    push(8'h00);
    at(56); chk("rst_hold_t55", {7'b0, q1});
    // Release exactly on the t=65 edge: the flop sees rst still high there.
    @(posedge clk);
    rst1 <= 1'b0;
    push(8'h00);
    at(66); chk("release_on_edge", {7'b0, q1});
    push(8'h01);
    at(76); chk("first_capture_after_release", {7'b0, q1});

    // 8-bit instance from the vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst8 = vecs[i].rst;
      d8   = vecs[i].d;
      push(vecs[i].exp);
      @(posedge clk);
      #1;
      chk(vecs[i].name, q8);
    end

    // d changing between edges must not reach q
    @(negedge clk);
    d8 = 8'h11;
    push(8'hC3);
    #2; chk("w8_d_between_edges", q8);

`ifdef ASYNC_D_FF_CE_EN
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0; ce1 = 1'b0; d1 = 1'b1;
    push(8'h00);
    @(posedge clk); #1;
    chk("ce0_hold", {7'b0, q1});
    @(negedge clk);
    ce1 = 1'b1;
    push(8'h01);
    @(posedge clk); #1;
    chk("ce1_capture", {7'b0, q1});
    @(negedge clk);
    ce1 = 1'b0; rst1 = 1'b1;
    push(8'h00);
    #1; chk("rst_over_ce", {7'b0, q1});
    @(posedge clk); #1;
    push(8'h00);
    chk("rst_over_ce_edge", {7'b0, q1});
    rst1 = 1'b0; ce1 = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
